// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response handshake and data_mem bus bundle for load_store_unit
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_w_en;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;

  // Requester and memory side (execute stage / data_mem)
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_r_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_w_en, mem_w_data
  );

  // Load/store unit side
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_r_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_w_en, mem_w_data
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store initiator for word-indexed data_mem (optional LSU_ERR_CNT_EN error counter)
module load_store_unit #(
  parameter int MEM_WORDS = 32
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus
`ifdef LSU_ERR_CNT_EN
  ,
  output logic [15:0]        err_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  state_t      state;
  logic [2:0]  funct3;
  logic [1:0]  lane;
  logic [31:0] wdata;
  logic        w_en;

  // Accept only when idle and out of reset; write strobe never leaks during reset.
  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.mem_w_en  = w_en && !rst;

  // Rejects illegal funct3, misaligned half/word and out-of-range word index.
  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic legal;
    logic misaligned;
    logic out_of_range;
    case (f3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !we;
      default:                legal = 1'b0;
    endcase
    misaligned   = ((f3[1:0] == 2'b01) && addr[0]) ||
                   ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    out_of_range = {2'b00, addr[31:2]} >= 32'(MEM_WORDS);
    return !legal || misaligned || out_of_range;
  endfunction

  // Picks the addressed byte/half from the read word and sign/zero extends it.
  function automatic logic [31:0] extend(input logic [31:0] word, input logic [2:0] f3, input logic [1:0] ln);
    logic [7:0]  b;
    logic [15:0] h;
    case (ln)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = ln[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  // Overlays the store byte/half onto the old word, leaving other lanes untouched.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [2:0] f3, input logic [1:0] ln);
    logic [31:0] m;
    m = old;
    if (f3[0]) begin
      if (ln[1]) m[31:16] = wd[15:0];
      else       m[15:0]  = wd[15:0];
    end else begin
      case (ln)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end
    return m;
  endfunction

  // Main sequencer: one outstanding request, all bus-facing outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      funct3         <= 3'b000;
      lane           <= 2'b00;
      wdata          <= 32'h0;
      w_en           <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_rdata  <= 32'h0;
      bus.rsp_err    <= 1'b0;
      bus.mem_addr   <= 32'h0;
      bus.mem_w_data <= 32'h0;
    end else begin
      w_en <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            funct3 <= bus.req_funct3;
            lane   <= bus.req_addr[1:0];
            wdata  <= bus.req_wdata;
            bus.rsp_rdata <= 32'h0;
            if (access_err(bus.req_we, bus.req_funct3, bus.req_addr)) begin
              bus.rsp_err   <= 1'b1;
              bus.rsp_valid <= 1'b1;
              state         <= RESP;
            end else begin
              bus.rsp_err  <= 1'b0;
              bus.mem_addr <= {2'b00, bus.req_addr[31:2]};
              if (!bus.req_we) begin
                state <= LOAD;
              end else if (bus.req_funct3 == 3'b010) begin
                bus.mem_w_data <= bus.req_wdata;
                w_en           <= 1'b1;
                state          <= WRITE;
              end else begin
                state <= RMW_RD;
              end
            end
          end
        end
        LOAD: begin
          bus.rsp_rdata <= extend(bus.mem_r_data, funct3, lane);
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RMW_RD: begin
          bus.mem_w_data <= merge(bus.mem_r_data, wdata, funct3, lane);
          w_en           <= 1'b1;
          state          <= WRITE;
        end
        WRITE: begin
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LSU_ERR_CNT_EN
  // Counts error responses as they are consumed, saturating at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 16'h0;
    end else if (bus.rsp_valid && bus.rsp_ready && bus.rsp_err && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
